// File: rtl/fp_issue_sched_if.sv
// Bundle of the decode, iterative-unit, writeback and flag signals of fp_issue_sched.
// The slave modport is the scheduler's view; the master modport is its environment.
interface fp_issue_sched_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [4:0]       in_rd;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] fast_result;
  logic [4:0]       fast_flags;

  logic             mc_start;
  logic [OP_W-1:0]  mc_op;
  logic [WIDTH-1:0] mc_a;
  logic [WIDTH-1:0] mc_b;
  logic             mc_done;
  logic [WIDTH-1:0] mc_result;
  logic [4:0]       mc_flags;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       out_rd;
  logic [4:0]       out_flags;

  logic             flush;
  logic [4:0]       fflags;
  logic             fflags_clr;
  logic             busy;
  logic             mc_err;

  modport slave (
    input  in_valid, in_op, in_rd, in_a, in_b, fast_result, fast_flags,
    input  mc_done, mc_result, mc_flags,
    input  out_ready, flush, fflags_clr,
    output in_ready, mc_start, mc_op, mc_a, mc_b,
    output out_valid, out_data, out_rd, out_flags,
    output fflags, busy, mc_err
  );

  modport master (
    output in_valid, in_op, in_rd, in_a, in_b, fast_result, fast_flags,
    output mc_done, mc_result, mc_flags,
    output out_ready, flush, fflags_clr,
    input  in_ready, mc_start, mc_op, mc_a, mc_b,
    input  out_valid, out_data, out_rd, out_flags,
    input  fflags, busy, mc_err
  );
endinterface

// File: rtl/fp_issue_sched.sv
// FP issue scheduler: routes fast ops straight to a one-entry writeback register and
// sequences fdiv/fsqrt through the shared iterative unit, with timeout and sticky fflags.
//
// state   | meaning
// IDLE    | no long op outstanding; decode may issue when writeback slot frees
// MC_BUSY | long op running in the iterative unit, result will be written back
// DRAIN   | long op was flushed; wait for its mc_done and drop the result
module fp_issue_sched #(
  parameter int WIDTH      = 32,
  parameter int OP_W       = 5,
  parameter int MC_TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  fp_issue_sched_if.slave bus
);
  localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [OP_W-1:0]  OP_FDIV  = OP_W'(5'h03);
  localparam logic [OP_W-1:0]  OP_FSQRT = OP_W'(5'h0B);

  typedef enum logic [1:0] {IDLE, MC_BUSY, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic [4:0]       mc_rd;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [4:0]       out_rd_q;
  logic [4:0]       out_flags_q;
  logic             mc_start_q;
  logic [OP_W-1:0]  mc_op_q;
  logic [WIDTH-1:0] mc_a_q;
  logic [WIDTH-1:0] mc_b_q;
  logic [4:0]       fflags_q;
  logic             busy_q;
  logic             mc_err_q;

  logic in_ready_c;
  logic accept;
  logic long_op;
  logic handshake;
  logic done_ok;

  assign in_ready_c = !rst && (state == IDLE) && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign long_op    = (bus.in_op == OP_FDIV) || (bus.in_op == OP_FSQRT);
  assign handshake  = out_valid_q && bus.out_ready;
  // The unit cannot finish in its own start cycle; a done there is stale.
  assign done_ok    = bus.mc_done && !mc_start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      mc_rd       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_flags_q <= '0;
      mc_start_q  <= 1'b0;
      mc_op_q     <= '0;
      mc_a_q      <= '0;
      mc_b_q      <= '0;
      fflags_q    <= '0;
      busy_q      <= 1'b0;
      mc_err_q    <= 1'b0;
    end else begin
      mc_start_q <= 1'b0;

      // Clear applies before the OR of a same-cycle writeback.
      if (handshake && !bus.flush) begin
        fflags_q <= (bus.fflags_clr ? 5'd0 : fflags_q) | out_flags_q;
      end else if (bus.fflags_clr) begin
        fflags_q <= '0;
      end

      if (handshake || bus.flush) begin
        out_valid_q <= 1'b0;
      end
      if (accept && !long_op) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.fast_result;
        out_rd_q    <= bus.in_rd;
        out_flags_q <= bus.fast_flags;
      end

      case (state)
        IDLE: begin
          if (accept && long_op) begin
            state      <= MC_BUSY;
            to_cnt     <= '0;
            mc_op_q    <= bus.in_op;
            mc_a_q     <= bus.in_a;
            mc_b_q     <= bus.in_b;
            mc_rd      <= bus.in_rd;
            mc_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        MC_BUSY, DRAIN: begin
          if (done_ok) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if ((state == MC_BUSY) && !bus.flush) begin
              out_valid_q <= 1'b1;
              out_data_q  <= bus.mc_result;
              out_rd_q    <= mc_rd;
              out_flags_q <= bus.mc_flags;
            end
          end else if (to_cnt == CNT_LAST) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            mc_err_q <= 1'b1;
          end else begin
            if (to_cnt != '1) begin
              to_cnt <= to_cnt + CNT_W'(1);
            end
            if (bus.flush) begin
              state <= DRAIN;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mc_start  = mc_start_q;
  assign bus.mc_op     = mc_op_q;
  assign bus.mc_a      = mc_a_q;
  assign bus.mc_b      = mc_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_flags = out_flags_q;
  assign bus.fflags    = fflags_q;
  assign bus.busy      = busy_q;
  assign bus.mc_err    = mc_err_q;
endmodule
